// File: rtl/timer_counter.sv
// timer_counter: memory-mapped down-counting timer with one-shot and auto-reload modes.
// Register map on Addr[1:0] (byte address bits [3:2]):
//   0 CTRL, 1 PRESET, 2 COUNT (read-only), 3 reserved (reads 0).
// Optional feature macro: TIMER_AUTORELOAD_EN enables mode 01 auto-reload.
// Without it, mode 01 is stored as 00 and the INT->LOAD path is not built.

package timer_counter_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 30;
  localparam int unsigned CTRL_W = 4;

  typedef enum logic [1:0] {
    REG_CTRL   = 2'd0,
    REG_PRESET = 2'd1,
    REG_COUNT  = 2'd2,
    REG_RSVD   = 2'd3
  } reg_sel_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  // CTRL layout: [3] IM, [2:1] Mode, [0] Enable
  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } ctrl_t;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

endpackage

module timer_counter
  import timer_counter_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] Addr,
  input  logic              WE,
  input  logic [DATA_W-1:0] Din,
  output logic [DATA_W-1:0] Dout,
  output logic              IRQ
);

  state_t            state_q, state_d;
  ctrl_t             ctrl_q, ctrl_d, ctrl_wr;
  logic [DATA_W-1:0] preset_q, preset_d;
  logic [DATA_W-1:0] count_q, count_d;
  logic              flag_q, flag_d;
  logic              irq_q, irq_d;
  logic              enter_int;

  reg_sel_t          sel;
  logic              ctrl_we;
  logic              preset_we;
  logic              unused_addr;

  // Only the low two word-address bits select a register; the bridge already decoded the rest
  assign sel         = reg_sel_t'(Addr[1:0]);
  assign ctrl_we     = WE && (sel == REG_CTRL);
  assign preset_we   = WE && (sel == REG_PRESET);
  assign unused_addr = ^Addr[ADDR_W-1:2];

  // Sanitise the CTRL write value: upper bits dropped, mode 01 folded when reload is absent
  always_comb begin
    ctrl_wr = ctrl_t'(Din[CTRL_W-1:0]);
`ifndef TIMER_AUTORELOAD_EN
    if (ctrl_wr.mode == MODE_RELOAD) begin
      ctrl_wr.mode = MODE_ONESHOT;
    end
`endif
  end

  // Next-state, counter, register-write and interrupt-flag logic
  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    preset_d  = preset_q;
    count_d   = count_q;
    flag_d    = flag_q;
    enter_int = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ctrl_q.en) begin
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        count_d = preset_q;
        state_d = S_CNT;
      end

      S_CNT: begin
        if (!ctrl_q.en) begin
          state_d = S_IDLE;
        end else if (count_q > DATA_W'(1)) begin
          count_d = count_q - DATA_W'(1);
        end else begin
          // COUNT is 1 or already 0: land on zero and raise the interrupt
          count_d   = '0;
          state_d   = S_INT;
          enter_int = 1'b1;
        end
      end

      S_INT: begin
`ifdef TIMER_AUTORELOAD_EN
        if (ctrl_q.mode == MODE_RELOAD) begin
          state_d = S_LOAD;
          flag_d  = 1'b0;
        end else begin
          state_d   = S_IDLE;
          ctrl_d.en = 1'b0;
        end
`else
        state_d   = S_IDLE;
        ctrl_d.en = 1'b0;
`endif
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A CPU CTRL write overrides the hardware Enable clear and acknowledges the flag
    if (ctrl_we) begin
      ctrl_d = ctrl_wr;
      flag_d = 1'b0;
    end

    // PRESET only feeds COUNT at the next LOAD, so a write here never disturbs counting
    if (preset_we) begin
      preset_d = Din;
    end

    // Expiry takes priority over a same-cycle acknowledge so no interrupt is lost
    if (enter_int) begin
      flag_d = 1'b1;
    end

    // IRQ is registered from next-state values so it appears on the same edge as the flag
    irq_d = flag_d & ctrl_d.im;
  end

  // State and register flops
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      ctrl_q   <= '0;
      preset_q <= '0;
      count_q  <= '0;
      flag_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
      irq_q    <= irq_d;
    end
  end

  // Zero-latency read mux
  always_comb begin
    Dout = '0;
    case (sel)
      REG_CTRL:   Dout = {{(DATA_W - CTRL_W){1'b0}}, ctrl_q};
      REG_PRESET: Dout = preset_q;
      REG_COUNT:  Dout = count_q;
      default:    Dout = '0;
    endcase
  end

  assign IRQ = irq_q;

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter. Expected values are queued as stimulus
// is driven and checked right after the next rising edge (or immediately).
// Expectations follow the TIMER_AUTORELOAD_EN setting of the build.

module tb_timer_counter;

  localparam logic [29:0] A_CTRL   = 30'd0;
  localparam logic [29:0] A_PRESET = 30'd1;
  localparam logic [29:0] A_COUNT  = 30'd2;
  localparam logic [29:0] A_RSVD   = 30'd3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [29:0] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  always #5 clk = ~clk;

  timer_counter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .Addr    (Addr),
    .WE      (WE),
    .Din     (Din),
    .Dout    (Dout),
    .IRQ     (IRQ)
  );

  typedef struct {
    string       tag;
    logic        is_irq;
    logic [29:0] addr;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic exp_rd(input string tag, input logic [29:0] a, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.is_irq = 1'b0; e.addr = a; e.val = v;
    sb.push_back(e);
  endtask

  task automatic exp_irq(input string tag, input logic v);
    exp_t e;
    e.tag = tag; e.is_irq = 1'b1; e.addr = 30'd0; e.val = {31'd0, v};
    sb.push_back(e);
  endtask

  // Compare every queued expectation against the DUT as it stands now
  task automatic drain();
    exp_t e;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      if (e.is_irq) begin
        check(e.tag, {31'd0, IRQ}, e.val);
      end else begin
        Addr = e.addr;
        #1;
        check(e.tag, Dout, e.val);
      end
    end
  endtask

  // One rising edge, then release any write strobe and check the queue
  task automatic step();
    @(posedge clk);
    #1;
    WE = 1'b0;
    drain();
  endtask

  task automatic wr(input logic [29:0] a, input logic [31:0] d);
    Addr = a;
    Din  = d;
    WE   = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    Addr    = '0;
    WE      = 1'b0;
    Din     = '0;

    // Reset state
    #2;
    exp_rd("rst_ctrl", A_CTRL, 32'h0);
    exp_rd("rst_preset", A_PRESET, 32'h0);
    exp_rd("rst_count", A_COUNT, 32'h0);
    exp_irq("rst_irq", 1'b0);
    drain();
    @(negedge clk);
    reset_n = 1'b1;

    // One-shot: PRESET=3, CTRL=0x9
    wr(A_PRESET, 32'd3); exp_rd("os_preset", A_PRESET, 32'd3); step();
    wr(A_CTRL, 32'h9); exp_rd("os_ctrl_wr", A_CTRL, 32'h9); step();   // E0
    exp_rd("os_e1_count", A_COUNT, 32'd0); exp_irq("os_e1_irq", 1'b0); step();
    for (int i = 0; i < 4; i++) begin                                 // E2..E5
      exp_rd($sformatf("os_count_e%0d", i + 2), A_COUNT, 32'(3 - i));
      exp_irq($sformatf("os_irq_e%0d", i + 2), i == 3);
      step();
    end
    for (int i = 6; i <= 8; i++) begin
      exp_irq($sformatf("os_irq_held_e%0d", i), 1'b1);
      exp_rd($sformatf("os_ctrl_e%0d", i), A_CTRL, 32'h8);
      step();
    end
    wr(A_CTRL, 32'h8); exp_irq("os_ack_irq", 1'b0); step();
    exp_irq("os_ack_irq2", 1'b0); step();

    // Auto-reload: PRESET=2, CTRL=0xB
    wr(A_PRESET, 32'd2); step();
    wr(A_CTRL, 32'hB);
`ifdef TIMER_AUTORELOAD_EN
    exp_rd("ar_ctrl_wr", A_CTRL, 32'hB);
`else
    exp_rd("ar_ctrl_wr", A_CTRL, 32'h9);
`endif
    step();                                                           // E0
    for (int k = 1; k <= 14; k++) begin
`ifdef TIMER_AUTORELOAD_EN
      exp_irq($sformatf("ar_irq_e%0d", k), (k % 4) == 0);
      if ((k % 4) == 2) exp_rd($sformatf("ar_count_e%0d", k), A_COUNT, 32'd2);
`else
      exp_irq($sformatf("ar_irq_e%0d", k), k >= 4);
      if (k == 2) exp_rd("ar_count_e2", A_COUNT, 32'd2);
      if (k == 6) exp_rd("ar_count_e6", A_COUNT, 32'd0);
`endif
      step();
    end
`ifdef TIMER_AUTORELOAD_EN
    exp_rd("ar_ctrl_end", A_CTRL, 32'hB);
`else
    exp_rd("ar_ctrl_end", A_CTRL, 32'h8);
`endif
    drain();
    wr(A_CTRL, 32'h0); exp_irq("ar_stop_irq", 1'b0); step();
    step(); step();

    // Mask: CTRL=0x1, PRESET=1 -> expiry without IRQ; later IM=1 still no IRQ
    wr(A_PRESET, 32'd1); step();
    wr(A_CTRL, 32'h1); step();                                        // E0
    for (int k = 1; k <= 5; k++) begin
      exp_irq($sformatf("mask_irq_e%0d", k), 1'b0);
      if (k == 3) exp_rd("mask_count_e3", A_COUNT, 32'd0);
      if (k == 5) exp_rd("mask_ctrl_e5", A_CTRL, 32'h0);
      step();
    end
    wr(A_CTRL, 32'h8); exp_irq("mask_im_irq", 1'b0); exp_rd("mask_im_ctrl", A_CTRL, 32'h8); step();
    exp_irq("mask_im_irq2", 1'b0); step();

    // Disable / PRESET change mid-count
    wr(A_CTRL, 32'h0); step();
    wr(A_PRESET, 32'd6); step();
    wr(A_CTRL, 32'h1); step();                                        // E0
    step();                                                           // E1 LOAD
    exp_rd("dis_count_e2", A_COUNT, 32'd6); step();
    exp_rd("dis_count_e3", A_COUNT, 32'd5); step();
    exp_rd("dis_count_e4", A_COUNT, 32'd4); step();
    wr(A_PRESET, 32'd10);
    exp_rd("dis_count_e5", A_COUNT, 32'd3); exp_rd("dis_preset_e5", A_PRESET, 32'd10); step();
    wr(A_CTRL, 32'h0); exp_rd("dis_count_e6", A_COUNT, 32'd2); step();
    exp_rd("dis_hold_e7", A_COUNT, 32'd2); step();
    exp_rd("dis_hold_e8", A_COUNT, 32'd2); step();
    wr(A_CTRL, 32'h1); exp_rd("dis_hold_e9", A_COUNT, 32'd2); step();
    exp_rd("dis_load_e10", A_COUNT, 32'd2); step();
    exp_rd("dis_reload_e11", A_COUNT, 32'd10); step();
    wr(A_CTRL, 32'h0); exp_rd("dis_count_e12", A_COUNT, 32'd9); step();
    exp_rd("dis_stop_e13", A_COUNT, 32'd9); step();

    // Writes to COUNT and offset 3 are ignored
    wr(A_COUNT, 32'h55);
    exp_rd("ro_count", A_COUNT, 32'd9); exp_rd("ro_preset", A_PRESET, 32'd10); step();
    wr(A_RSVD, 32'hFFFF_FFFF);
    exp_rd("rsvd_read", A_RSVD, 32'h0); exp_rd("rsvd_ctrl", A_CTRL, 32'h0);
    exp_rd("rsvd_preset", A_PRESET, 32'd10); exp_rd("rsvd_count", A_COUNT, 32'd9); step();

    // PRESET=0 expires at E3; then CTRL write coincident with the INT-state Enable clear
    wr(A_PRESET, 32'd0); step();
    wr(A_CTRL, 32'h9); step();                                        // E0
    exp_irq("p0_irq_e1", 1'b0); step();
    exp_irq("p0_irq_e2", 1'b0); exp_rd("p0_count_e2", A_COUNT, 32'd0); step();
    exp_irq("p0_irq_e3", 1'b1); step();
    wr(A_CTRL, 32'hD);
    exp_rd("coin_ctrl_e4", A_CTRL, 32'hD); exp_irq("coin_irq_e4", 1'b0); step();
    exp_irq("coin_irq_e5", 1'b0); step();
    exp_irq("coin_irq_e6", 1'b0); step();
    exp_irq("m2_irq_e7", 1'b1); step();
    exp_irq("m2_irq_e8", 1'b1); exp_rd("m2_ctrl_e8", A_CTRL, 32'hC); step();
    wr(A_CTRL, 32'h0); exp_irq("m2_ack_irq", 1'b0); step();

    // Asynchronous reset mid-count with COUNT=5
    wr(A_PRESET, 32'd8); step();
    wr(A_CTRL, 32'h9); step();                                        // E0
    step();                                                           // E1
    step(); step(); step();                                           // E2..E4
    exp_rd("mr_count_e5", A_COUNT, 32'd5); step();
    #2;
    reset_n = 1'b0;
    #1;
    exp_rd("mr_count", A_COUNT, 32'h0);
    exp_rd("mr_ctrl", A_CTRL, 32'h0);
    exp_rd("mr_preset", A_PRESET, 32'h0);
    exp_irq("mr_irq", 1'b0);
    drain();
    @(negedge clk);
    reset_n = 1'b1;
    step(); step();
    exp_rd("mr_idle_count", A_COUNT, 32'h0); exp_rd("mr_idle_ctrl", A_CTRL, 32'h0);
    exp_irq("mr_idle_irq", 1'b0); step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
